warning_tone_scheduler: RTL and testbench
=========================================

Name: warning_tone_scheduler

Overview:
- Shares one physical speaker and tone generator among the three obstacle-warning channels (left/centre/right speaker requests from the sensor warning FSM).
- Grants one channel at a time in round-robin time slices, separated by silent gaps.
- During its slot, drives a channel-specific square-wave tone so the user can tell which direction raised the warning.
- Sits between the warning state machine outputs and the single speaker pin on uo_out.

Parameters:
- SLOT_CYCLES, 1000, length of one tone slot in clk cycles; valid range 1..2^24-1.
- GAP_CYCLES, 200, length of the silent gap after each slot in clk cycles; valid range 1..2^24-1.
- TONE_DIV0, 50, half-period of channel 0 tone in cycles; valid range 1..65535.
- TONE_DIV1, 40, half-period of channel 1 tone in cycles; valid range 1..65535.
- TONE_DIV2, 30, half-period of channel 2 tone in cycles; valid range 1..65535.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; low forces return to idle.
- req  input  3  level warning requests; bit k = channel k (from speaker1..speaker3).
- grant  output  3  one-hot registered grant; all zero when no channel is playing.
- tone_out  output  1  registered square wave to the speaker.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, grant = 000, tone_out = 0, slot counter = 0, tone counter = 0, rr pointer = 2 (so channel 0 wins first).
- All state changes below happen on the rising edge of clk.
- Arbitration (round-robin):
  - Search order starts at pointer+1 modulo 3 and takes the first set req bit.
  - The pointer is updated to the granted index when its slot ends, whether it completes or aborts.
- IDLE:
  - If ena=1 and any req bit is set at edge N, go to PLAY with grant = winner, slot counter = 0, tone counter = 0, tone_out = 0.
  - grant is visible in the cycle after edge N (1-cycle latency).
- PLAY (lasts exactly SLOT_CYCLES cycles unless aborted):
  - The slot counter increments every cycle.
  - The tone counter increments every cycle. When it equals TONE_DIVk-1 for the granted channel k, it wraps to 0 and tone_out toggles.
  - When the slot counter equals SLOT_CYCLES-1: go to GAP, grant = 000, tone_out = 0, gap counter = 0.
- Abort: if req[granted] is sampled 0 in PLAY, go to GAP on that edge (grant = 000, tone_out = 0). Abort takes precedence over slot end on the same edge; the result is identical.
- GAP (lasts exactly GAP_CYCLES cycles):
  - grant = 000 and tone_out = 0 throughout.
  - On the last gap cycle: if any req bit is set, go to PLAY with the next round-robin winner; otherwise go to IDLE.
- ena low: at the next edge, from any state, go to IDLE with grant = 000 and tone_out = 0. The rr pointer is retained. While ena is low, nothing leaves IDLE.
- busy is combinational: busy = (state != IDLE).
- A single persistent requester is re-granted after every gap, giving a periodic beep.
- New requests that arrive during PLAY or GAP are not granted until the gap ends. There is no preemption.
- grant is always one-hot or zero, and tone_out is 0 whenever grant is 000.
- Reset asserted mid-slot returns immediately (asynchronously) to the reset values.
- Counter widths: slot and gap counters are 24 bits; the tone counter is 16 bits. No counter overflows for legal parameters.

Test Plan:
Bench parameters: SLOT_CYCLES=8, GAP_CYCLES=2, TONE_DIV0=2, TONE_DIV1=3, TONE_DIV2=1.
1. Reset values: hold rst_n=0 with req=111 → grant=000, tone_out=0, busy=0. Assert rst_n asynchronously mid-PLAY → outputs clear immediately, without waiting for a clock edge.
2. Single channel 0: req=001 from cycle 0 → grant=001 from cycle 1 for 8 cycles; tone_out=0,0,1,1,0,0,1,1; then 2 cycles of grant=000; then grant=001 again.
3. All channels requesting after reset: req=111 held → grant sequence 001, 010, 100, 001, with 2 silent cycles between slots. Channel 1 tone toggles every 3 cycles; channel 2 tone toggles every cycle.
4. Abort: req=010 held; drop req[1] at PLAY cycle 3 → grant=000 and tone_out=0 on the next edge; after 2 gap cycles, state = IDLE and busy=0.
5. Fairness after abort: req=011; abort channel 0 mid-slot while req[1] stays high → next grant is 010, not 001.
6. ena gating: drop ena during PLAY → next edge gives grant=000, tone_out=0, busy=0. Raise ena with req=101 and pointer=0 → grant=100.

Source files
------------

// File: rtl/warning_tone_scheduler.sv
// Round-robin scheduler that shares one speaker among three warning channels,
// playing a channel-specific square-wave tone per slot with silent gaps in between.
module warning_tone_scheduler #(
  parameter int unsigned SLOT_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 200,
  parameter int unsigned TONE_DIV0   = 50,
  parameter int unsigned TONE_DIV1   = 40,
  parameter int unsigned TONE_DIV2   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       tone_out,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam logic [23:0] SLOT_LAST = 24'(SLOT_CYCLES - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

  state_t      r_state;
  logic [23:0] r_cnt;       // slot counter in PLAY, gap counter in GAP
  logic [15:0] r_tone_cnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_ch;
  logic [2:0]  r_grant;
  logic        r_tone;

  logic [1:0]  w_first;
  logic [1:0]  w_second;
  logic [1:0]  w_win;
  logic        w_any;
  logic [15:0] w_div_last;
  logic        w_slot_end;

  // Search order is ptr+1, ptr+2, ptr (all modulo 3).
  always_comb begin
    w_first    = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_second   = (w_first == 2'd2) ? 2'd0 : w_first + 2'd1;
    w_any      = |req;
    w_win      = req[w_first] ? w_first : (req[w_second] ? w_second : r_ptr);
    w_slot_end = !req[r_ch] || (r_cnt == SLOT_LAST);
    case (r_ch)
      2'd0:    w_div_last = 16'(TONE_DIV0 - 1);
      2'd1:    w_div_last = 16'(TONE_DIV1 - 1);
      default: w_div_last = 16'(TONE_DIV2 - 1);
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, exactly like the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tone_cnt <= '0;
      r_ptr      <= 2'd2;
      r_ch       <= 2'd0;
      r_grant    <= '0;
      r_tone     <= 1'b0;
    end else if (!ena) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tone_cnt <= '0;
      r_grant    <= '0;
      r_tone     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_PLAY;
            r_ch       <= w_win;
            r_grant    <= 3'(3'b001 << w_win);
            r_cnt      <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
          end
        end
        S_PLAY: begin
          if (w_slot_end) begin
            r_state    <= S_GAP;
            r_ptr      <= r_ch;
            r_grant    <= '0;
            r_tone     <= 1'b0;
            r_cnt      <= '0;
            r_tone_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 24'd1;
            if (r_tone_cnt == w_div_last) begin
              r_tone_cnt <= '0;
              r_tone     <= ~r_tone;
            end else begin
              r_tone_cnt <= r_tone_cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt      <= '0;
            r_tone_cnt <= '0;
            if (w_any) begin
              r_state <= S_PLAY;
              r_ch    <= w_win;
              r_grant <= 3'(3'b001 << w_win);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_tone  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign tone_out = r_tone;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_warning_tone_scheduler.sv
// Bench for warning_tone_scheduler: directed literal scenarios plus a long
// randomized run compared every cycle against a slot/gap-level reference model.
module tb_warning_tone_scheduler;

  localparam int SLOT = 8;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic       tone_out;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model: phase 0 = idle, 1 = playing, 2 = silent gap; m_t = cycles spent in phase.
  int m_phase = 0;
  int m_ch    = 0;
  int m_t     = 0;
  int m_ptr   = 2;

  warning_tone_scheduler #(
    .SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP),
    .TONE_DIV0(2), .TONE_DIV1(3), .TONE_DIV2(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .grant(grant), .tone_out(tone_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic int div_of(input int ch);
    return (ch == 0) ? 2 : ((ch == 1) ? 3 : 1);
  endfunction

  function automatic int pick(input logic [2:0] r, input int p);
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (p + i) % 3;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_t = 0; m_ptr = 2; m_ch = 0;
    end else if (!ena) begin
      m_phase = 0; m_t = 0;
    end else begin
      case (m_phase)
        0: if (req != 3'b000) begin m_phase = 1; m_ch = pick(req, m_ptr); m_t = 0; end
        1: if (!req[m_ch] || m_t == SLOT - 1) begin
             m_ptr = m_ch; m_phase = 2; m_t = 0;
           end else m_t++;
        default: if (m_t == GAP - 1) begin
             m_t = 0;
             if (req != 3'b000) begin m_phase = 1; m_ch = pick(req, m_ptr); end
             else m_phase = 0;
           end else m_t++;
      endcase
    end
  end

  // Tone in a slot is a square wave with half-period DIV, starting low.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      logic [2:0] eg;
      logic       et;
      eg = (m_phase == 1) ? 3'(3'b001 << m_ch) : 3'b000;
      et = (m_phase == 1) ? 1'((m_t / div_of(m_ch)) % 2) : 1'b0;
      check("model_grant", 32'(grant), 32'(eg));
      check("model_tone", 32'(tone_out), 32'(et));
      check("model_busy", 32'(busy), 32'(m_phase != 0));
    end
  end

  task automatic start(input logic [2:0] r);
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = r;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_slot(input logic [2:0] g, input logic [7:0] pat);
    for (int i = 0; i < SLOT; i++) begin
      @(negedge clk);
      check($sformatf("slot_grant_c%0d", i), 32'(grant), 32'(g));
      check($sformatf("slot_tone_c%0d", i), 32'(tone_out), 32'(pat[i]));
    end
  endtask

  task automatic expect_gap();
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      check("gap_grant", 32'(grant), 32'd0);
      check("gap_tone", 32'(tone_out), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] r;
    cmp_en = 1'b1;

    // Reset values while requests are active.
    rst_n = 1'b0; ena = 1'b1; req = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tone", 32'(tone_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single channel 0, periodic beep, then async reset mid-slot.
    start(3'b001);
    expect_slot(3'b001, 8'b1100_1100);
    expect_gap();
    @(negedge clk);
    check("rebeep_grant", 32'(grant), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_tone", 32'(tone_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);

    // All channels requesting: 001, 010, 100, 001.
    start(3'b111);
    expect_slot(3'b001, 8'b1100_1100);
    expect_gap();
    expect_slot(3'b010, 8'b0011_1000);
    expect_gap();
    expect_slot(3'b100, 8'b1010_1010);
    expect_gap();
    @(negedge clk);
    check("rr_wrap_grant", 32'(grant), 32'd1);

    // Abort of channel 1 at play cycle 3, then back to idle.
    start(3'b010);
    repeat (3) begin
      @(negedge clk);
      check("abort_pre_grant", 32'(grant), 32'd2);
    end
    req = 3'b000;
    @(negedge clk);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_tone", 32'(tone_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort_gap2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_grant", 32'(grant), 32'd0);

    // Fairness: aborting channel 0 still advances the pointer.
    start(3'b011);
    repeat (3) begin
      @(negedge clk);
      check("fair_pre_grant", 32'(grant), 32'd1);
    end
    req = 3'b010;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("fair_next_grant", 32'(grant), 32'd2);

    // ena gating with pointer at channel 0.
    start(3'b001);
    expect_slot(3'b001, 8'b1100_1100);
    expect_gap();
    @(negedge clk);
    check("ena_pre_grant", 32'(grant), 32'd1);
    ena = 1'b0;
    @(negedge clk);
    check("ena_off_grant", 32'(grant), 32'd0);
    check("ena_off_tone", 32'(tone_out), 32'd0);
    check("ena_off_busy", 32'(busy), 32'd0);
    req = 3'b111;
    repeat (2) begin
      @(negedge clk);
      check("ena_hold_busy", 32'(busy), 32'd0);
    end
    ena = 1'b1;
    req = 3'b101;
    @(negedge clk);
    check("ena_on_grant", 32'(grant), 32'd4);

    // Randomized run checked by the model every cycle.
    start(3'($urandom));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = $urandom;
      if (r % 10 == 0) req = 3'($urandom);
      if (r % 60 == 1) ena = 1'b0;
      else if (!ena && (r % 4 == 0)) ena = 1'b1;
      if (r % 500 == 7) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
